result_writeback: RTL

//   Drains the MAC_COUNT accumulator results of the matrix-vector multiplier back to memory.

---
 rtl/mlab_pkg.sv | 16 +
 rtl/result_writeback.sv | 100 ++++++++++
 2 files changed

// File: rtl/mlab_pkg.sv
// Shared constants and types for the matrix-vector multiplier datapath blocks.
package mlab_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int MAC_COUNT  = 8;
   localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WRITE,
      WB_DONE
   } wb_state_t;

   typedef logic [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/result_writeback.sv
// Drains the MAC accumulator results to memory through an Avalon-MM style write master.
// All results are snapshotted on start, then written one word per accepted beat.
module result_writeback #(
   parameter int                    DATA_WIDTH  = mlab_pkg::DATA_WIDTH,
   parameter int                    MAC_COUNT   = mlab_pkg::MAC_COUNT,
   parameter int                    ACC_WIDTH   = 3 * DATA_WIDTH,
   parameter int                    MEM_WIDTH   = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000,
   parameter int                    ADDR_STRIDE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ACC_WIDTH-1:0]  C_in [0:MAC_COUNT-1],
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  write,
   output logic [MEM_WIDTH-1:0]  writedata,
   input  logic                  waitrequest,
   output logic                  busy,
   output logic                  done
);

   import mlab_pkg::*;

   localparam int              IDX_W    = (MAC_COUNT > 1) ? $clog2(MAC_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAC_COUNT - 1);

   generate
      if (ACC_WIDTH > MEM_WIDTH) begin : g_width_check
         $error("result_writeback: ACC_WIDTH (%0d) exceeds MEM_WIDTH (%0d)", ACC_WIDTH, MEM_WIDTH);
      end
   endgenerate

   wb_state_t            state, state_next;
   logic [ACC_WIDTH-1:0] shadow [0:MAC_COUNT-1];
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_inc;
   logic                 accept;
   logic                 last_beat;

   assign accept    = (state == WB_WRITE) && !waitrequest;
   assign last_beat = (idx == LAST_IDX);
   assign idx_inc   = idx + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= WB_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         WB_IDLE:  if (start)                 state_next = WB_WRITE;
         WB_WRITE: if (accept && last_beat)   state_next = WB_DONE;
         WB_DONE:                             state_next = WB_IDLE;
         default:                             state_next = WB_IDLE;
      endcase
   end

   // write is exactly "in WRITE", so it needs no register of its own.
   always_comb begin
      write = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         WB_WRITE: begin
            write = 1'b1;
            busy  = 1'b1;
         end
         WB_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         address   <= '0;
         writedata <= '0;
         // NOTE: the shadow array is deliberately reset so a post-reset read never exposes stale results.
         for (int i = 0; i < MAC_COUNT; i++) shadow[i] <= '0;
      end else if ((state == WB_IDLE) && start) begin
         for (int i = 0; i < MAC_COUNT; i++) shadow[i] <= C_in[i];
         idx       <= '0;
         address   <= BASE_ADDR;
         // shadow is still being loaded this edge, so beat 0 comes straight from C_in.
         writedata <= MEM_WIDTH'(C_in[0]);
      end else if (accept && !last_beat) begin
         idx       <= idx_inc;
         address   <= address + ADDR_WIDTH'(ADDR_STRIDE);
         writedata <= MEM_WIDTH'(shadow[idx_inc]);
      end
   end

endmodule
